// File: rtl/csr_file_hpm.sv
// Machine-mode CSR file: mstatus/mie/mtvec/mscratch/mepc/mcause, mcountinhibit,
// mcycle/minstret and NUM_HPM performance counters with read-only Cxx aliases.
// Reads return the pre-update value; writes and trap/mret updates land at the next edge.
module csr_file_hpm #(
  parameter int unsigned NUM_HPM   = 4,
  parameter int unsigned CNT_WIDTH = 64,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [11:0]                           csr_addr_i,
  input  logic [1:0]                            csr_op_i,
  input  logic [31:0]                           csr_wdata_i,
  output logic [31:0]                           csr_rdata_o,
  output logic                                  csr_illegal_o,
  input  logic                                  retire_i,
  input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event_i,
  input  logic                                  trap_i,
  input  logic [31:0]                           trap_cause_i,
  input  logic [31:0]                           trap_pc_i,
  input  logic                                  mret_i,
  output logic [31:0]                           trap_vector_o,
  output logic [31:0]                           mepc_o,
  output logic [31:0]                           mie_o,
  output logic                                  global_int_en_o
);

  // Counter slots follow the CSR address low bits: 0 cycle, 1 (time, absent), 2 instret, 3+ hpm.
  localparam int NCNT = 3 + NUM_HPM;
  localparam logic [31:0] INH_MASK = 32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << 3);

  logic                 mstatus_mie_q, mstatus_mpie_q;
  logic [31:0]          mie_q, mscratch_q, mepc_q, mcause_q, mcountinhibit_q;
  logic [29:0]          mtvec_base_q;
  logic [1:0]           mtvec_mode_q;
  logic [CNT_WIDTH-1:0] cnt_q [NCNT];

  logic [31:0] mstatus_rd, rd_val, wv;
  logic        mapped, is_alias, is_cnt, cnt_hi, wr_attempt, illegal, wr_en, cnt_wr;
  logic [4:0]  cnt_idx;
  logic [63:0] cnt_sel;
  logic [NCNT-1:0] cnt_ev;

  function automatic logic cnt_impl(input logic [4:0] k);
    return (k == 5'd0) || (k == 5'd2) || (k >= 5'd3 && int'(k) < NCNT);
  endfunction

  assign mstatus_rd = {19'b0, 2'b11, 3'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
  assign cnt_idx    = csr_addr_i[4:0];
  assign cnt_hi     = csr_addr_i[7];

  // Address decode and old-value read mux.
  always_comb begin
    mapped   = 1'b0;
    is_alias = 1'b0;
    is_cnt   = 1'b0;
    rd_val   = 32'h0;
    cnt_sel  = 64'h0;
    for (int k = 0; k < NCNT; k++)
      if (int'(cnt_idx) == k) cnt_sel = 64'(cnt_q[k]);
    case (csr_addr_i)
      12'h300: begin mapped = 1'b1; rd_val = mstatus_rd; end
      12'h304: begin mapped = 1'b1; rd_val = mie_q; end
      12'h305: begin mapped = 1'b1; rd_val = {mtvec_base_q, mtvec_mode_q}; end
      12'h320: begin mapped = 1'b1; rd_val = mcountinhibit_q; end
      12'h340: begin mapped = 1'b1; rd_val = mscratch_q; end
      12'h341: begin mapped = 1'b1; rd_val = mepc_q; end
      12'h342: begin mapped = 1'b1; rd_val = mcause_q; end
      default: begin
        if ((csr_addr_i[11:8] == 4'hB || csr_addr_i[11:8] == 4'hC) &&
            csr_addr_i[6:5] == 2'b00 && cnt_impl(cnt_idx)) begin
          mapped   = 1'b1;
          is_cnt   = 1'b1;
          is_alias = (csr_addr_i[11:8] == 4'hC);
          rd_val   = cnt_hi ? cnt_sel[63:32] : cnt_sel[31:0];
        end
      end
    endcase
  end

  // Set/clear with a zero operand is a pure read, which keeps csrrs/csrrc x0 legal on aliases.
  assign wr_attempt    = (csr_op_i != 2'b00) && !(csr_op_i[1] && csr_wdata_i == 32'h0);
  assign illegal       = !mapped || (is_alias && wr_attempt);
  assign wr_en         = wr_attempt && !illegal;
  assign cnt_wr        = wr_en && is_cnt;
  assign csr_illegal_o = illegal;
  assign csr_rdata_o   = illegal ? 32'h0 : rd_val;

  // Read-modify-write value from the op code.
  always_comb begin
    case (csr_op_i)
      2'b10:   wv = rd_val | csr_wdata_i;
      2'b11:   wv = rd_val & ~csr_wdata_i;
      default: wv = csr_wdata_i;
    endcase
  end

  // Per-counter increment sources.
  always_comb begin
    cnt_ev    = '0;
    cnt_ev[0] = 1'b1;
    cnt_ev[2] = retire_i;
    for (int i = 0; i < NUM_HPM; i++) cnt_ev[3+i] = hpm_event_i[i];
  end

  // Control registers: trap beats mret beats CSR write on the registers they share.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q   <= 1'b0;
      mstatus_mpie_q  <= 1'b0;
      mie_q           <= 32'h0;
      mtvec_base_q    <= MTVEC_RST[31:2];
      mtvec_mode_q    <= MTVEC_RST[1:0];
      mcountinhibit_q <= 32'h0;
      mscratch_q      <= 32'h0;
      mepc_q          <= 32'h0;
      mcause_q        <= 32'h0;
    end else begin
      if (wr_en) begin
        case (csr_addr_i)
          12'h300: if (!trap_i && !mret_i) begin
            mstatus_mie_q  <= wv[3];
            mstatus_mpie_q <= wv[7];
          end
          12'h304: mie_q <= wv;
          12'h305: begin
            mtvec_base_q <= wv[31:2];
            mtvec_mode_q <= wv[1] ? 2'b00 : wv[1:0];
          end
          12'h320: mcountinhibit_q <= wv & INH_MASK;
          12'h340: mscratch_q <= wv;
          12'h341: if (!trap_i) mepc_q <= wv & ~32'h3;
          12'h342: if (!trap_i) mcause_q <= wv;
          default: ;
        endcase
      end
      if (trap_i) begin
        mepc_q         <= trap_pc_i & ~32'h3;
        mcause_q       <= trap_cause_i;
        mstatus_mpie_q <= mstatus_mie_q;
        mstatus_mie_q  <= 1'b0;
      end else if (mret_i) begin
        mstatus_mie_q  <= mstatus_mpie_q;
        mstatus_mpie_q <= 1'b1;
      end
    end
  end

  // Counters: a write to either half suppresses that counter's increment for the cycle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCNT; k++) begin
      if (rst || !cnt_impl(5'(k))) begin
        cnt_q[k] <= '0;
      end else if (cnt_wr && int'(cnt_idx) == k) begin
        if (cnt_hi) cnt_q[k] <= {wv[CNT_WIDTH-33:0], cnt_q[k][31:0]};
        else        cnt_q[k] <= {cnt_q[k][CNT_WIDTH-1:32], wv};
      end else if (cnt_ev[k] && !mcountinhibit_q[k]) begin
        cnt_q[k] <= cnt_q[k] + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign trap_vector_o   = (mtvec_mode_q == 2'b01 && trap_cause_i[31])
                         ? ({mtvec_base_q, 2'b00} + {25'b0, trap_cause_i[4:0], 2'b00})
                         : {mtvec_base_q, 2'b00};
  assign mepc_o          = mepc_q;
  assign mie_o           = mie_q;
  assign global_int_en_o = mstatus_mie_q;

endmodule

// File: tb/tb_csr_file_hpm.sv
// Scoreboard bench for csr_file_hpm: stimulus queues expected observations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_csr_file_hpm;

  localparam int S_RDATA = 0, S_ILL = 1, S_TVEC = 2, S_MEPC = 3, S_GIE = 4, S_MIE = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] csr_addr = 12'h0;
  logic [1:0]  csr_op = 2'b00;
  logic [31:0] csr_wdata = 32'h0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        retire = 1'b0;
  logic [3:0]  hpm_event = 4'h0;
  logic        trap = 1'b0;
  logic [31:0] trap_cause = 32'h0;
  logic [31:0] trap_pc = 32'h0;
  logic        mret = 1'b0;
  logic [31:0] trap_vector, mepc, mie;
  logic        gie;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  csr_file_hpm #(.NUM_HPM(4), .CNT_WIDTH(64), .MTVEC_RST(32'h0)) dut (
    .clk(clk), .rst(rst),
    .csr_addr_i(csr_addr), .csr_op_i(csr_op), .csr_wdata_i(csr_wdata),
    .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal),
    .retire_i(retire), .hpm_event_i(hpm_event),
    .trap_i(trap), .trap_cause_i(trap_cause), .trap_pc_i(trap_pc), .mret_i(mret),
    .trap_vector_o(trap_vector), .mepc_o(mepc), .mie_o(mie), .global_int_en_o(gie)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // Monitor: compare every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (sb.size() != 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sel)
        S_RDATA: act = csr_rdata;
        S_ILL:   act = {31'b0, csr_illegal};
        S_TVEC:  act = trap_vector;
        S_MEPC:  act = mepc;
        S_GIE:   act = {31'b0, gie};
        default: act = mie;
      endcase
      checks++;
      if (act !== e.exp) begin
        failures++;
        $display("FAIL %s got=%h expected=%h", e.name, act, e.exp);
      end
    end
  end

  task automatic step(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
    @(posedge clk);
    #1;
    csr_addr   = a;
    csr_op     = op;
    csr_wdata  = wd;
    retire     = 1'b0;
    hpm_event  = 4'h0;
    trap       = 1'b0;
    mret       = 1'b0;
    trap_cause = 32'h0;
    trap_pc    = 32'h0;
  endtask

  task automatic expect_val(input string n, input int s, input logic [31:0] v);
    sb.push_back('{n, s, v});
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    step(12'h300, 2'b00, 0); rst = 1'b0;
    expect_val("rst_mstatus", S_RDATA, 32'h1800);
    expect_val("rst_gie", S_GIE, 0);
    expect_val("rst_mepc", S_MEPC, 0);
    expect_val("rst_mie", S_MIE, 0);
    expect_val("rst_legal", S_ILL, 0);
    step(12'hB00, 2'b00, 0); expect_val("mcycle_first", S_RDATA, 1);
    step(12'hC00, 2'b00, 0); expect_val("cycle_alias", S_RDATA, 2);

    // mstatus masking and clear
    step(12'h300, 2'b01, 32'hFFFF_FFFF); expect_val("mstatus_no_bypass", S_RDATA, 32'h1800);
    step(12'h300, 2'b11, 32'h8);
    expect_val("mstatus_all", S_RDATA, 32'h1888);
    expect_val("gie_set", S_GIE, 1);
    step(12'h300, 2'b00, 0);
    expect_val("mstatus_clr", S_RDATA, 32'h1880);
    expect_val("gie_clr", S_GIE, 0);

    // mcycle carry across halves
    step(12'h320, 2'b01, 32'h7C); expect_val("inh_old", S_RDATA, 0);
    step(12'h320, 2'b00, 0);      expect_val("inh_7c", S_RDATA, 32'h7C);
    step(12'hB00, 2'b01, 32'hFFFF_FFFF);
    step(12'hB80, 2'b01, 0);      expect_val("mcycleh_old", S_RDATA, 0);
    step(12'h320, 2'b01, 32'hFFFF_FFFF); expect_val("inh_old2", S_RDATA, 32'h7C);
    step(12'hB80, 2'b00, 0);      expect_val("mcycleh_carry", S_RDATA, 1);
    step(12'hB00, 2'b00, 0);      expect_val("mcycle_wrap", S_RDATA, 0);
    step(12'h320, 2'b00, 0);      expect_val("inh_mask", S_RDATA, 32'h7D);

    // minstret inhibited, then counting
    for (int i = 0; i < 3; i++) begin
      step(12'hB02, 2'b00, 0); retire = 1'b1; expect_val("minstret_inh", S_RDATA, 0);
    end
    step(12'hB02, 2'b00, 0);      expect_val("minstret_unch", S_RDATA, 0);
    step(12'h320, 2'b11, 32'h4);  expect_val("inh_old3", S_RDATA, 32'h7D);
    step(12'hB02, 2'b00, 0); retire = 1'b1; expect_val("minstret_0", S_RDATA, 0);
    step(12'hB02, 2'b00, 0); retire = 1'b1; expect_val("minstret_1", S_RDATA, 1);
    step(12'hB02, 2'b00, 0);      expect_val("minstret_2", S_RDATA, 2);

    // hpm counters
    step(12'h320, 2'b11, 32'h8);  expect_val("inh_old4", S_RDATA, 32'h79);
    step(12'hB03, 2'b00, 0); hpm_event = 4'b0011; expect_val("hpm3_0", S_RDATA, 0);
    step(12'hB03, 2'b00, 0);      expect_val("hpm3_1", S_RDATA, 1);
    step(12'hB04, 2'b00, 0);      expect_val("hpm4_inh", S_RDATA, 0);
    step(12'hC84, 2'b00, 0);      expect_val("hpm4h_alias", S_RDATA, 0);
    expect_val("hpm4h_legal", S_ILL, 0);

    // write beats increment
    step(12'hB02, 2'b01, 32'h5); retire = 1'b1; expect_val("minstret_old", S_RDATA, 2);
    step(12'hB02, 2'b00, 0);      expect_val("minstret_wr_wins", S_RDATA, 5);

    // illegal accesses
    step(12'hC00, 2'b01, 32'h1);
    expect_val("alias_wr_ill", S_ILL, 1);
    expect_val("alias_wr_rd0", S_RDATA, 0);
    step(12'h7C0, 2'b01, 32'h1);  expect_val("unmapped_ill", S_ILL, 1);
    step(12'hB01, 2'b00, 0);      expect_val("time_ill", S_ILL, 1);
    step(12'hB07, 2'b00, 0);      expect_val("hpm_oob_ill", S_ILL, 1);
    step(12'hC00, 2'b10, 0);
    expect_val("alias_set0_legal", S_ILL, 0);
    expect_val("alias_set0_rd", S_RDATA, 0);

    // mtvec and vectored traps
    step(12'h305, 2'b01, 32'h1001); expect_val("mtvec_old", S_RDATA, 0);
    step(12'h305, 2'b00, 0); trap_cause = 32'h8000_0007;
    expect_val("mtvec_rd", S_RDATA, 32'h1001);
    expect_val("tvec_irq7", S_TVEC, 32'h101C);
    step(12'h305, 2'b00, 0); trap_cause = 32'h2;
    expect_val("tvec_exc", S_TVEC, 32'h1000);
    step(12'h305, 2'b01, 32'h2003);
    step(12'h305, 2'b00, 0); trap_cause = 32'h8000_0007;
    expect_val("mtvec_warl", S_RDATA, 32'h2000);
    expect_val("tvec_direct", S_TVEC, 32'h2000);

    // mie register
    step(12'h304, 2'b01, 32'h888); expect_val("mie_old", S_RDATA, 0);
    step(12'h304, 2'b00, 0);       expect_val("mie_out", S_MIE, 32'h888);

    // trap / mret stacking
    step(12'h300, 2'b01, 32'h8);
    step(12'h300, 2'b00, 0);
    expect_val("mstatus_mie1", S_RDATA, 32'h1808);
    expect_val("gie_before_trap", S_GIE, 1);
    step(12'h341, 2'b01, 32'h1234); trap = 1'b1; trap_pc = 32'h203; trap_cause = 32'hB;
    expect_val("mepc_old", S_RDATA, 0);
    step(12'h300, 2'b00, 0);
    expect_val("trap_mstatus", S_RDATA, 32'h1880);
    expect_val("trap_mepc", S_MEPC, 32'h200);
    expect_val("trap_gie", S_GIE, 0);
    step(12'h342, 2'b00, 0);       expect_val("trap_mcause", S_RDATA, 32'hB);
    step(12'h300, 2'b00, 0); mret = 1'b1; expect_val("mret_old", S_RDATA, 32'h1880);
    step(12'h300, 2'b00, 0);
    expect_val("mret_mstatus", S_RDATA, 32'h1888);
    expect_val("mret_gie", S_GIE, 1);
    step(12'h300, 2'b01, 0); mret = 1'b1;
    step(12'h300, 2'b00, 0);       expect_val("mret_beats_wr", S_RDATA, 32'h1888);
    step(12'h341, 2'b01, 32'h307); expect_val("mepc_rd", S_RDATA, 32'h200);
    step(12'h341, 2'b00, 0);       expect_val("mepc_align", S_MEPC, 32'h304);

    // reset overrides trap and write
    step(12'h341, 2'b01, 32'h4); rst = 1'b1; trap = 1'b1; trap_pc = 32'h400;
    step(12'h300, 2'b00, 0); rst = 1'b0;
    expect_val("rst2_mstatus", S_RDATA, 32'h1800);
    expect_val("rst2_mepc", S_MEPC, 0);
    expect_val("rst2_mie", S_MIE, 0);
    step(12'h305, 2'b00, 0);       expect_val("rst2_mtvec", S_RDATA, 0);
    step(12'h320, 2'b00, 0);       expect_val("rst2_inh", S_RDATA, 0);

    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain got=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
